// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N requesters.
// Each write is a HOLD-cycle write_to_FIFO level followed by at least GAP low cycles.
module fifo_write_arbiter #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int HOLD = 2,
    parameter int GAP  = 2,
    parameter int CW   = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] wdata,
    input  logic           fifo_full,
    output logic           write_to_FIFO,
    output logic [W-1:0]   fifo_wdata,
    output logic [N-1:0]   grant,
    output logic           busy,
    output logic [CW-1:0]  write_count
);

    localparam int LW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = $clog2(HOLD + 1);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_GAP
    } state_t;

    state_t        state;
    logic [LW-1:0] last;
    logic [LW-1:0] current;
    logic [LW-1:0] winner;
    logic [HW-1:0] hold_cnt;
    logic [GW-1:0] gap_cnt;
    logic          found;
    logic          accept;
    logic [W-1:0]  winner_data;
    int            cand;

    // Search starts just after the last winner, so the last winner has lowest priority.
    always_comb begin
        // NOTE: every variable gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
        found  = 1'b0;
        winner = last;
        cand   = 0;
        for (int i = 1; i <= N; i++) begin
            cand = (int'(last) + i) % N;
            if (!found && req[cand[LW-1:0]]) begin
                found  = 1'b1;
                winner = cand[LW-1:0];
            end
        end
    end

    always_comb begin
        winner_data = '0;
        for (int i = 0; i < N; i++) begin
            if (winner == LW'(i)) begin
                winner_data = wdata[i*W +: W];
            end
        end
    end

    // fifo_full only gates the choice of a new winner; a started write always finishes.
    assign accept = found && !fifo_full;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= ST_IDLE;
            write_to_FIFO <= 1'b0;
            fifo_wdata    <= '0;
            grant         <= '0;
            busy          <= 1'b0;
            write_count   <= '0;
            last          <= LW'(N - 1);
            current       <= '0;
            hold_cnt      <= '0;
            gap_cnt       <= '0;
        end else begin
            grant <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        current       <= winner;
                        fifo_wdata    <= winner_data;
                        write_to_FIFO <= 1'b1;
                        hold_cnt      <= HW'(1);
                        busy          <= 1'b1;
                        state         <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    if (hold_cnt < HW'(HOLD)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else begin
                        write_to_FIFO <= 1'b0;
                        grant         <= N'(1) << current;
                        write_count   <= write_count + 1'b1;
                        last          <= current;
                        gap_cnt       <= GW'(1);
                        state         <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    if (gap_cnt < GW'(GAP)) begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end else if (accept) begin
                        // Back-to-back: the final gap cycle doubles as the next acceptance.
                        current       <= winner;
                        fifo_wdata    <= winner_data;
                        write_to_FIFO <= 1'b1;
                        hold_cnt      <= HW'(1);
                        state         <= ST_WRITE;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    write_to_FIFO <= 1'b0;
                    busy          <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single FIFO write port between N requesters using round-robin arbitration.
- Sequences each write as a stretched write_to_FIFO level of HOLD cycles followed by a GAP-cycle low period. This lets the downstream write_synchronizer, clocked on the opposite edge or in another domain, capture every write as one distinct pulse.
- Returns a one-cycle grant acknowledge to the winning requester and counts completed writes.

Parameters:
N, 4, number of requesters (2..8)
W, 8, data width per requester
HOLD, 2, cycles write_to_FIFO is held high per write (>=1)
GAP, 2, minimum cycles write_to_FIFO is low between writes (>=1)
CW, 8, width of write_count

Ports:
clock  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-low reset (0 = reset)
req  input  N  per-requester write request, level, held until grant
wdata  input  N*W  requester data, slice i = wdata[i*W+W-1 : i*W]
fifo_full  input  1  FIFO full flag, already in this clock domain
write_to_FIFO  output  1  write strobe to write_synchronizer
fifo_wdata  output  W  data latched from the winning requester
grant  output  N  one-hot, one-cycle acknowledge of a completed write
busy  output  1  high whenever state != IDLE
write_count  output  CW  completed writes, wraps modulo 2^CW

Behaviour:
- Reset is sampled at posedge clock with reset==0.
  - Reset values: state=IDLE, write_to_FIFO=0, fifo_wdata=0, grant=0, busy=0, write_count=0, rr pointer last=N-1 (requester 0 has highest priority first).
  - Reset mid-WRITE or mid-GAP aborts immediately. The aborted write earns no grant and no count.
- FSM states:
  - IDLE: if |req and !fifo_full, pick the winner, latch its wdata slice into fifo_wdata, set write_to_FIFO=1, hold_cnt=1, go to WRITE. Otherwise stay.
  - WRITE: write_to_FIFO stays 1.
    - If hold_cnt < HOLD, increment it.
    - Else set write_to_FIFO=0, grant[winner]=1 for exactly one cycle, write_count+1, last=winner, gap_cnt=1, go to GAP.
  - GAP: write_to_FIFO=0.
    - If gap_cnt < GAP, increment it.
    - Else apply the IDLE evaluation in the same cycle: either go to WRITE with a new winner, or go to IDLE.
- Winner selection: first asserted req searching indices last+1, last+2, ... modulo N.
- Timing, with request accepted at edge k:
  - write_to_FIFO high after edges k..k+HOLD-1.
  - grant high after edge k+HOLD.
  - Earliest next write_to_FIFO rise at edge k+HOLD+GAP.
  - Peak throughput: one write per HOLD+GAP cycles.
- fifo_full is sampled only when choosing a winner (IDLE, or the final GAP cycle). A write in progress always completes, even if fifo_full rises.
- Once accepted, a write is committed.
  - req deassertion during WRITE or GAP does not cancel it.
  - fifo_wdata holds the latched value until the next acceptance. It is not updated from wdata mid-write.
- Requester protocol:
  - Drop req, or present new data, on the cycle after grant.
  - A req still high at re-evaluation is treated as a new request.
- grant is never asserted for a requester whose req was low at acceptance. grant is never multi-hot.
- write_count wraps from 2^CW-1 to 0 with no flag.

Test Plan:
1. Reset=0 for 3 cycles with req=4'b1111 -> all outputs 0 throughout; after release, first grant goes to requester 0.
2. Single request, N=4, W=8, HOLD=2, GAP=2: req=4'b0100, wdata slice2=8'hA5, accepted at edge k.
   - write_to_FIFO=1 for exactly 2 cycles, fifo_wdata=8'hA5.
   - grant=4'b0100 for 1 cycle after edge k+2.
   - write_count=1, busy drops after edge k+4.
3. All four requesting continuously with data 8'h10..8'h13 -> grants in order 0,1,2,3,0.
   - write_to_FIFO rising edges exactly 4 cycles apart.
   - fifo_wdata sequence 10,11,12,13,10.
4. fifo_full=1 with req=4'b0001 -> no write for 10 cycles.
   - fifo_full drops -> write starts the next edge.
   - fifo_full raised during WRITE -> that write still completes and grants.
5. Reset driven low during the second WRITE cycle -> write_to_FIFO=0 and no grant next cycle, write_count unchanged, rr pointer back to requester 0 priority.
6. CW=2, 5 back-to-back writes -> write_count reads 1,2,3,0,1.
